// File: rtl/pal_sync_gen_pkg.sv
// Common types, PAL default geometry and a range helper for the PAL sync generator.
package pal_sync_gen_pkg;
`include "video_timing.vh"

  localparam int unsigned PAL_H_TOTAL      = `PAL_H_TOTAL;
  localparam int unsigned PAL_H_SYNC       = `PAL_H_SYNC;
  localparam int unsigned PAL_H_ACT_START  = `PAL_H_ACT_START;
  localparam int unsigned PAL_H_ACT_LEN    = `PAL_H_ACT_LEN;
  localparam int unsigned PAL_V_SYNC_LINES = `PAL_V_SYNC_LINES;
  localparam int unsigned PAL_V_ACT_START  = `PAL_V_ACT_START;
  localparam int unsigned PAL_V_ACT_LEN    = `PAL_V_ACT_LEN;
  localparam int unsigned PAL_V_TOTAL      = `PAL_V_TOTAL;

  localparam logic HS_ACTIVE = `TV_HS_ACTIVE;
  localparam logic VS_ACTIVE = `TV_VS_ACTIVE;

  typedef logic [10:0] hcount_t;
  typedef logic [9:0]  vcount_t;

  function automatic logic in_span(input logic [10:0] val,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (val >= lo) && (val < hi);
  endfunction
endpackage

// File: rtl/pal_sync_gen_hv_counter.sv
// Raster position counters: these hold the position the top presents on the next cycle,
// including per-field line count, field toggle and the mode latch sampled at field wrap.
module pal_sync_gen_hv_counter
  import pal_sync_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL = PAL_H_TOTAL,
  parameter int unsigned V_TOTAL = PAL_V_TOTAL
) (
  input  logic        i_clk24,
  input  logic        i_rst_n,
  input  logic        i_mode_interlace,
  output logic [10:0] o_h,
  output logic [9:0]  o_v,
  output logic        o_field
);

  localparam hcount_t H_LAST     = hcount_t'(H_TOTAL - 1);
  localparam vcount_t V_LAST_EVN = vcount_t'(V_TOTAL - 1);
  localparam vcount_t V_LAST_ODD = vcount_t'(V_TOTAL);

  hcount_t r_h;
  vcount_t r_v;
  logic    r_field;
  logic    r_mode;

  logic    w_line_end;
  logic    w_last_line;

  // The odd field of an interlaced frame carries the extra (313th) line.
  assign w_line_end  = (r_h == H_LAST);
  assign w_last_line = (r_mode && r_field) ? (r_v == V_LAST_ODD) : (r_v == V_LAST_EVN);

  always_ff @(posedge i_clk24 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h     <= '0;
      r_v     <= '0;
      r_field <= 1'b0;
      r_mode  <= 1'b0;
    end else if (w_line_end) begin
      r_h <= '0;
      if (w_last_line) begin
        r_v     <= '0;
        r_mode  <= i_mode_interlace;
        r_field <= i_mode_interlace ? ~r_field : 1'b0;
      end else begin
        r_v <= r_v + 10'd1;
      end
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign o_h     = r_h;
  assign o_v     = r_v;
  assign o_field = r_field;

endmodule

// File: rtl/video_timing.vh
// Shared PAL raster defaults and sync polarities, used by the sync generator, encoder and
// framebuffer fetch.
`ifndef VIDEO_TIMING_VH
`define VIDEO_TIMING_VH

`define PAL_H_TOTAL      1536
`define PAL_H_SYNC       113
`define PAL_H_ACT_START  256
`define PAL_H_ACT_LEN    1216
`define PAL_V_SYNC_LINES 3
`define PAL_V_ACT_START  23
`define PAL_V_ACT_LEN    288
`define PAL_V_TOTAL      312

`define TV_HS_ACTIVE 1'b0
`define TV_VS_ACTIVE 1'b0

`endif

// File: rtl/pal_sync_gen.sv
// Free-running PAL raster timing generator: sync, blanking, data-enable, coordinates and strobes,
// all registered together so every output describes the same pixel.
module pal_sync_gen
  import pal_sync_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL      = PAL_H_TOTAL,
  parameter int unsigned H_SYNC       = PAL_H_SYNC,
  parameter int unsigned H_ACT_START  = PAL_H_ACT_START,
  parameter int unsigned H_ACT_LEN    = PAL_H_ACT_LEN,
  parameter int unsigned V_SYNC_LINES = PAL_V_SYNC_LINES,
  parameter int unsigned V_ACT_START  = PAL_V_ACT_START,
  parameter int unsigned V_ACT_LEN    = PAL_V_ACT_LEN,
  parameter int unsigned V_TOTAL      = PAL_V_TOTAL
) (
  input  logic        clk24,
  input  logic        rst_n,
  input  logic        mode_interlace,
  output logic        tv_hs_o,
  output logic        tv_vs_o,
  output logic        tv_porch_o,
  output logic        de_o,
  output logic [10:0] pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic        field_o,
  output logic        line_stb_o,
  output logic        field_stb_o
);

  localparam hcount_t C_HSYNC = hcount_t'(H_SYNC);
  localparam hcount_t C_HALF  = hcount_t'(H_TOTAL / 2);
  localparam hcount_t C_ACTH0 = hcount_t'(H_ACT_START);
  localparam hcount_t C_ACTH1 = hcount_t'(H_ACT_START + H_ACT_LEN);
  localparam vcount_t C_VSYNC = vcount_t'(V_SYNC_LINES);
  localparam vcount_t C_ACTV0 = vcount_t'(V_ACT_START);
  localparam vcount_t C_ACTV1 = vcount_t'(V_ACT_START + V_ACT_LEN);

  hcount_t w_h;
  vcount_t w_v;
  logic    w_field;
  logic    w_hs_on;
  logic    w_vs_on;
  logic    w_active;

  hcount_t r_x;
  vcount_t r_y;
  logic    r_field;
  logic    r_hs;
  logic    r_vs;
  logic    r_porch;
  logic    r_de;
  logic    r_line_stb;
  logic    r_field_stb;

  pal_sync_gen_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv_counter (
    .i_clk24          (clk24),
    .i_rst_n          (rst_n),
    .i_mode_interlace (mode_interlace),
    .o_h              (w_h),
    .o_v              (w_v),
    .o_field          (w_field)
  );

  // Odd-field vsync is shifted by half a line, giving the interlace offset.
  assign w_hs_on = (w_h < C_HSYNC);
  assign w_vs_on = w_field
                 ? (((w_v == '0) && (w_h >= C_HALF)) ||
                    ((w_v != '0) && (w_v < C_VSYNC)) ||
                    ((w_v == C_VSYNC) && (w_h < C_HALF)))
                 : (w_v < C_VSYNC);
  assign w_active = in_span(w_h, C_ACTH0, C_ACTH1) &&
                    in_span({1'b0, w_v}, {1'b0, C_ACTV0}, {1'b0, C_ACTV1});

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_field     <= 1'b0;
      r_hs        <= ~HS_ACTIVE;
      r_vs        <= ~VS_ACTIVE;
      r_porch     <= 1'b1;
      r_de        <= 1'b0;
      r_line_stb  <= 1'b0;
      r_field_stb <= 1'b0;
    end else begin
      r_x         <= w_h;
      r_y         <= w_v;
      r_field     <= w_field;
      r_hs        <= w_hs_on ? HS_ACTIVE : ~HS_ACTIVE;
      r_vs        <= w_vs_on ? VS_ACTIVE : ~VS_ACTIVE;
      r_porch     <= ~w_active;
      r_de        <= w_active;
      r_line_stb  <= (w_h == '0);
      r_field_stb <= (w_h == '0) && (w_v == '0);
    end
  end

  assign tv_hs_o     = r_hs;
  assign tv_vs_o     = r_vs;
  assign tv_porch_o  = r_porch;
  assign de_o        = r_de;
  assign pix_x_o     = r_x;
  assign pix_y_o     = r_y;
  assign field_o     = r_field;
  assign line_stb_o  = r_line_stb;
  assign field_stb_o = r_field_stb;

endmodule

// File: tb/tb_pal_sync_gen.sv
// Scoreboard bench for pal_sync_gen on a shrunken raster: a linear-position reference model
// queues the expected output word each clock and a negedge monitor compares it with the DUT.
module tb_pal_sync_gen;

  localparam int TB_H    = 40;
  localparam int TB_HS   = 5;
  localparam int TB_HAS  = 10;
  localparam int TB_HAL  = 24;
  localparam int TB_VSL  = 3;
  localparam int TB_VAS  = 4;
  localparam int TB_VAL  = 10;
  localparam int TB_VT   = 20;
  localparam int MAX_FAILS = 20;

  localparam logic [27:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0};

  logic        clk24;
  logic        rst_n;
  logic        mode_interlace;
  logic        tv_hs_o;
  logic        tv_vs_o;
  logic        tv_porch_o;
  logic        de_o;
  logic [10:0] pix_x_o;
  logic [9:0]  pix_y_o;
  logic        field_o;
  logic        line_stb_o;
  logic        field_stb_o;

  int checks = 0;
  int failures = 0;

  logic [27:0] expQ[$];

  int m_t = 0;
  bit m_field = 1'b0;
  int m_curX = 0;
  int m_curY = 0;
  bit m_curField = 1'b0;

  pal_sync_gen #(
    .H_TOTAL      (TB_H),
    .H_SYNC       (TB_HS),
    .H_ACT_START  (TB_HAS),
    .H_ACT_LEN    (TB_HAL),
    .V_SYNC_LINES (TB_VSL),
    .V_ACT_START  (TB_VAS),
    .V_ACT_LEN    (TB_VAL),
    .V_TOTAL      (TB_VT)
  ) dut (
    .clk24          (clk24),
    .rst_n          (rst_n),
    .mode_interlace (mode_interlace),
    .tv_hs_o        (tv_hs_o),
    .tv_vs_o        (tv_vs_o),
    .tv_porch_o     (tv_porch_o),
    .de_o           (de_o),
    .pix_x_o        (pix_x_o),
    .pix_y_o        (pix_y_o),
    .field_o        (field_o),
    .line_stb_o     (line_stb_o),
    .field_stb_o    (field_stb_o)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  function automatic logic [27:0] actualVec();
    return {tv_hs_o, tv_vs_o, tv_porch_o, de_o, line_stb_o, field_stb_o, field_o, pix_x_o, pix_y_o};
  endfunction

  // Expected outputs for linear position t within a field (t = y*H + x).
  function automatic logic [27:0] expectVec(input int t, input bit fld);
    int x;
    int y;
    bit hs;
    bit vs;
    bit act;
    x   = t % TB_H;
    y   = t / TB_H;
    hs  = !(x < TB_HS);
    if (fld)
      vs = !((t >= TB_H / 2) && (t < TB_VSL * TB_H + TB_H / 2));
    else
      vs = !(y < TB_VSL);
    act = (x >= TB_HAS) && (x < TB_HAS + TB_HAL) && (y >= TB_VAS) && (y < TB_VAS + TB_VAL);
    return {hs, vs, !act, act, (x == 0), (x == 0 && y == 0), fld, 11'(x), 10'(y)};
  endfunction

  task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got=%h want=%h (got x=%0d y=%0d, want x=%0d y=%0d)",
               name, $time, act, exp, act[20:10], act[9:0], exp[20:10], exp[9:0]);
      if (failures >= MAX_FAILS) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  // Reference model: advances one position per clock and queues what the DUT must show.
  always @(posedge clk24) begin
    int len;
    if (!rst_n) begin
      m_t     = 0;
      m_field = 1'b0;
      m_curX  = 0;
      m_curY  = 0;
      m_curField = 1'b0;
      expQ.push_back(RESET_VEC);
    end else begin
      expQ.push_back(expectVec(m_t, m_field));
      m_curX     = m_t % TB_H;
      m_curY     = m_t / TB_H;
      m_curField = m_field;
      len = (m_field ? TB_VT + 1 : TB_VT) * TB_H;
      if (m_t == len - 1) begin
        m_t     = 0;
        m_field = mode_interlace ? !m_field : 1'b0;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  // Monitor: every cycle presents an output word, compared half a cycle after the edge.
  always @(negedge clk24) begin
    if (expQ.size() > 0) checkOutput("outputs", actualVec(), expQ.pop_front());
  end

  task automatic applyStimulus(input int cycles, input logic mode);
    mode_interlace = mode;
    repeat (cycles) @(negedge clk24);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    mode_interlace = 1'b0;
    repeat (20) @(negedge clk24);
    #1 checkOutput("reset_hold", actualVec(), RESET_VEC);
    @(negedge clk24);
    rst_n = 1'b1;

    applyStimulus(2 * TB_VT * TB_H + 50, 1'b0);
    applyStimulus(4 * (TB_VT + 1) * TB_H, 1'b1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(200, 900), mode_interlace);
      mode_interlace = 1'($urandom_range(0, 1));
    end

    // Reach an odd-field position mid-line, then reset without a clock edge.
    mode_interlace = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk24);
      if (m_curField && m_curY == 10 && m_curX == 17) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL odd_field_reach: got=not reached want=field1 x=17 y=10");
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", actualVec(), RESET_VEC);
    repeat (5) @(negedge clk24);
    rst_n = 1'b1;
    applyStimulus(3 * (TB_VT + 1) * TB_H, 1'b1);
    applyStimulus(2 * TB_VT * TB_H, 1'b0);

    @(negedge clk24);
    @(negedge clk24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
